pwm_multi: RTL and testbench



---
 rtl/pwm_pkg.sv | 18 +
 rtl/pwm_chan.sv | 40 ++++
 rtl/pwm_multi.sv | 136 +++++++++++++
 tb/tb_pwm_multi.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM block.
// Counter states, mode encodings and channel-index width.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  function automatic int chan_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: staged and active duty registers, compare
// against the shared counter, and a registered output.
module pwm_chan
  import pwm_pkg::*;
#(
  parameter int   WIDTH = 10,
  parameter logic INV   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_duty,
  input  logic             load,
  input  logic             run,
  input  logic [WIDTH-1:0] cnt,
  output logic             pwm
);

  logic [WIDTH-1:0] duty_stg;
  logic [WIDTH-1:0] duty_act;
  logic             raw;

  assign raw = (cnt < duty_act);

  // load samples duty_stg before this edge's write lands
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_stg <= '0;
      duty_act <= '0;
      pwm      <= INV;
    end else begin
      if (wr)
        duty_stg <= wr_duty;
      if (load)
        duty_act <= duty_stg;
      pwm <= run ? (raw ^ INV) : INV;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared edge/center-aligned period counter
// with double-buffered period, mode and per-channel duty.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int                NUM_CH   = 2,
  parameter int                WIDTH    = 10,
  parameter logic [NUM_CH-1:0] INV_MASK = '0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic [WIDTH-1:0]                  period,
  input  logic                              center,
  input  logic                              wr_en,
  input  logic [chan_idx_w(NUM_CH)-1:0]     wr_ch,
  input  logic [WIDTH-1:0]                  wr_duty,
  input  logic                              update,
  output logic                              update_pend,
  output logic                              period_start,
  output logic [NUM_CH-1:0]                 pwm_out
);

  localparam int CW = chan_idx_w(NUM_CH);

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_n;
  logic [WIDTH-1:0] p_act;
  logic             c_act;
  logic             wrap;
  logic             at_top;
  logic             commit;
  logic             idle;
  logic             run;
  logic             load;

  assign idle   = (state == IDLE);
  assign run    = en && !idle;
  assign at_top = (cnt == p_act);
  assign commit = en && wrap && (update_pend || update);
  assign load   = idle || commit;

  // center mode with P==1 has no down-slope: 0,1 then wrap
  always_comb begin
    wrap = 1'b0;
    unique case (1'b1)
      (state == UP):
        wrap = (p_act == '0) || (at_top &&
               (c_act == MODE_EDGE || p_act == WIDTH'(1)));
      (state == DOWN):
        wrap = (cnt == WIDTH'(1));
      default:
        wrap = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (!en) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n = UP;
          cnt_n   = '0;
        end
        UP: begin
          if (wrap) begin
            cnt_n = '0;
          end else if (c_act == MODE_CENTER && at_top) begin
            state_n = DOWN;
            cnt_n   = cnt - WIDTH'(1);
          end else begin
            cnt_n = cnt + WIDTH'(1);
          end
        end
        DOWN: begin
          if (wrap) begin
            state_n = UP;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt - WIDTH'(1);
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      p_act        <= '0;
      c_act        <= MODE_EDGE;
      update_pend  <= 1'b0;
      period_start <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (load) begin
        p_act <= period;
        c_act <= center;
      end
      if (idle || commit)
        update_pend <= 1'b0;
      else if (update)
        update_pend <= 1'b1;
      period_start <= run && (cnt == '0);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_chan #(
      .WIDTH (WIDTH),
      .INV   (INV_MASK[i])
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr      (wr_en && (wr_ch == CW'(i))),
      .wr_duty (wr_duty),
      .load    (load),
      .run     (run),
      .cnt     (cnt),
      .pwm     (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: table of period shapes plus
// hand sequences for shadowing, same-cycle commit, reset, disable.
module tb_pwm_multi;

  localparam int         NCH = 2;
  localparam int         W   = 8;
  localparam logic [1:0] INV = 2'b10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [W-1:0] period = '0;
  logic         center = 1'b0;
  logic         wr_en = 1'b0;
  logic [0:0]   wr_ch = '0;
  logic [W-1:0] wr_duty = '0;
  logic         update = 1'b0;
  logic         update_pend;
  logic         period_start;
  logic [1:0]   pwm_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          p;
    logic        c;
    int          d0;
    int          d1;
    int          len;
    logic [31:0] pat;
    int          hi1;
  } vec_t;

  vec_t vecs[9];

  pwm_multi #(
    .NUM_CH   (NCH),
    .WIDTH    (W),
    .INV_MASK (INV)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .period       (period),
    .center       (center),
    .wr_en        (wr_en),
    .wr_ch        (wr_ch),
    .wr_duty      (wr_duty),
    .update       (update),
    .update_pend  (update_pend),
    .period_start (period_start),
    .pwm_out      (pwm_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wr(input int ch, input int d);
    wr_en   = 1'b1;
    wr_ch   = 1'(ch);
    wr_duty = W'(d);
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic set_idle(input int p, input logic c,
                          input int d0, input int d1);
    en = 1'b0;
    tick();
    period = W'(p);
    center = c;
    wr(0, d0);
    wr(1, d1);
    tick();
    tick();
    en = 1'b1;
  endtask

  task automatic wait_ps();
    int n;
    n = 0;
    while (!period_start && n < 64) begin
      tick();
      n++;
    end
    if (!period_start) begin
      checks++;
      errors++;
      $display("FAIL ps_timeout: got 0 expected 1");
    end
  endtask

  task automatic measure(output int len, output logic [31:0] pat,
                         output int hi1);
    wait_ps();
    len = 0;
    pat = '0;
    hi1 = 0;
    do begin
      if (len < 32)
        pat[len] = pwm_out[0];
      hi1 += int'(pwm_out[1]);
      len++;
      tick();
    end while (!period_start && len < 40);
  endtask

  initial begin
    int          len;
    int          hi0;
    int          hi1;
    logic [31:0] pat;

    vecs[0] = '{9, 1'b0, 3,   0,  10, 32'h7,   10};
    vecs[1] = '{9, 1'b0, 10,  5,  10, 32'h3FF, 5};
    vecs[2] = '{9, 1'b0, 255, 9,  10, 32'h3FF, 1};
    vecs[3] = '{9, 1'b0, 0,   10, 10, 32'h0,   0};
    vecs[4] = '{4, 1'b1, 2,   1,  8,  32'h83,  7};
    vecs[5] = '{4, 1'b1, 5,   4,  8,  32'hFF,  1};
    vecs[6] = '{0, 1'b0, 1,   0,  1,  32'h1,   1};
    vecs[7] = '{1, 1'b1, 1,   2,  2,  32'h1,   0};
    vecs[8] = '{3, 1'b0, 2,   3,  4,  32'h3,   1};

    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_pwm", int'(pwm_out), int'(INV));
    chk("rst_ps", int'(period_start), 0);
    chk("rst_pend", int'(update_pend), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      set_idle(vecs[i].p, vecs[i].c, vecs[i].d0, vecs[i].d1);
      measure(len, pat, hi1);
      chk($sformatf("v%0d_len", i), len, vecs[i].len);
      chk($sformatf("v%0d_pat", i), int'(pat), int'(vecs[i].pat));
      chk($sformatf("v%0d_hi1", i), hi1, vecs[i].hi1);
    end

    set_idle(9, 1'b0, 3, 4);
    wait_ps();
    hi0 = 0;
    for (int k = 0; k < 10; k++) begin
      hi0 += int'(pwm_out[0]);
      if (k == 3) chk("sh_pend_k3", int'(update_pend), 0);
      if (k == 4) chk("sh_pend_k4", int'(update_pend), 1);
      if (k == 8) chk("sh_pend_k8", int'(update_pend), 1);
      if (k == 9) chk("sh_pend_k9", int'(update_pend), 0);
      if (k == 3) begin
        wr_en   = 1'b1;
        wr_ch   = 1'b0;
        wr_duty = W'(7);
        update  = 1'b1;
      end
      tick();
      wr_en  = 1'b0;
      update = 1'b0;
    end
    chk("sh_ps", int'(period_start), 1);
    chk("sh_old_hi", hi0, 3);
    measure(len, pat, hi1);
    chk("sh_len", len, 10);
    chk("sh_new_pat", int'(pat), 32'h7F);
    chk("sh_hi1", hi1, 6);

    for (int k = 0; k < 8; k++)
      tick();
    update  = 1'b1;
    wr_en   = 1'b1;
    wr_ch   = 1'b0;
    wr_duty = W'(5);
    tick();
    update = 1'b0;
    wr_en  = 1'b0;
    chk("same_pend", int'(update_pend), 0);
    tick();
    chk("same_ps", int'(period_start), 1);
    measure(len, pat, hi1);
    chk("same_old_pat", int'(pat), 32'h7F);
    update = 1'b1;
    tick();
    update = 1'b0;
    chk("same_pend2", int'(update_pend), 1);
    measure(len, pat, hi1);
    chk("same_new_pat", int'(pat), 32'h1F);

    for (int k = 0; k < 4; k++)
      tick();
    update = 1'b1;
    tick();
    update = 1'b0;
    chk("rstm_pend_pre", int'(update_pend), 1);
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    chk("rstm_pwm", int'(pwm_out), int'(INV));
    chk("rstm_pend", int'(update_pend), 0);
    chk("rstm_ps", int'(period_start), 0);
    rst_n = 1'b1;
    measure(len, pat, hi1);
    chk("rstm_len", len, 10);
    chk("rstm_pat", int'(pat), 0);
    chk("rstm_hi1", hi1, 10);

    set_idle(9, 1'b0, 5, 0);
    wait_ps();
    for (int k = 0; k < 3; k++)
      tick();
    en = 1'b0;
    tick();
    chk("dis_pwm", int'(pwm_out), int'(INV));
    chk("dis_ps", int'(period_start), 0);
    tick();
    tick();
    chk("dis_pwm2", int'(pwm_out), int'(INV));
    en = 1'b1;
    tick();
    chk("ren_ps0", int'(period_start), 0);
    tick();
    chk("ren_ps1", int'(period_start), 1);
    chk("ren_pwm0", int'(pwm_out[0]), 1);
    measure(len, pat, hi1);
    chk("ren_len", len, 10);
    chk("ren_pat", int'(pat), 32'h1F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
